// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multicycle RV32I-subset controller: opcodes, FSM states,
// ALU op classes and datapath select encodings.
package multicycle_controller_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } aluop_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(logic [6:0] opcode);
        case (opcode)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's ALU op class plus funct fields to the ALU control code.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  aluop_e     aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        unique case (aluop)
            AluOpAdd: alu_control = ALU_ADD;
            AluOpSub: alu_control = ALU_SUB;
            AluOpFunct: begin
                case (funct3)
                    // Only R-type sets op5; addi ignores instr[30].
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I-subset CPU; drives datapath selects,
// enables and the ALU control code.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       reg_write
);

    state_e state_q, state_d;
    aluop_e aluop;
    logic   pc_update, branch;
    logic   mem_write_st, ir_write_st, reg_write_st;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= StFetch;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_R:         state_d = StExecuteR;
                    OP_I:         state_d = StExecuteI;
                    OP_JAL:       state_d = StJal;
                    OP_BEQ:       state_d = StBeq;
                    default:      state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = (opcode == OP_LW) ? StMemRead : StMemWrite;
            StMemRead:  state_d = StMemWb;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            StJal:      state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    always_comb begin
        adr_src      = 1'b0;
        mem_write_st = 1'b0;
        ir_write_st  = 1'b0;
        reg_write_st = 1'b0;
        result_src   = RES_ALUOUT;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RD2;
        aluop        = AluOpAdd;
        pc_update    = 1'b0;
        branch       = 1'b0;
        case (state_q)
            StFetch: begin
                ir_write_st = 1'b1;
                alu_src_b   = SRCB_FOUR;
                result_src  = RES_ALURESULT;
                pc_update   = 1'b1;
            end
            StDecode: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            StMemAdr: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            StMemRead: adr_src = 1'b1;
            StMemWb: begin
                result_src   = RES_READDATA;
                reg_write_st = 1'b1;
            end
            StMemWrite: begin
                adr_src      = 1'b1;
                mem_write_st = 1'b1;
            end
            StExecuteR: begin
                alu_src_a = SRCA_RD1;
                aluop     = AluOpFunct;
            end
            StExecuteI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                aluop     = AluOpFunct;
            end
            StAluWb: reg_write_st = 1'b1;
            StJal: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            StBeq: begin
                alu_src_a = SRCA_RD1;
                aluop     = AluOpSub;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset so nothing commits while the FSM is held in FETCH.
    assign pc_write  = ~reset & (pc_update | (branch & zero));
    assign ir_write  = ~reset & ir_write_st;
    assign mem_write = ~reset & mem_write_st;
    assign reg_write = ~reset & reg_write_st;
    assign imm_src   = imm_src_of(opcode);

    alu_decoder u_alu_decoder (
        .aluop       (aluop),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (opcode[5]),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: vector table, reset corner case and
// randomized instructions against a per-cycle reference model.
module tb_multicycle_controller;

    logic       clock, reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5, zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, JAL = 7'b1101111, BEQ = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] alu;
        logic [1:0] imm;
        logic       reg_write;
    } ctl_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         len;
        logic [2:0] key_alu;
        logic       key_pw;
        logic [1:0] imm;
    } vec_t;

    multicycle_controller dut (
        .clock       (clock),
        .reset       (reset),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .imm_src     (imm_src),
        .reg_write   (reg_write)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int instr_len(logic [6:0] op);
        case (op)
            LW:      return 5;
            SW, RT, IT, JAL: return 4;
            BEQ:     return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [1:0] imm_ref(logic [6:0] op);
        case (op)
            SW:      return 2'b01;
            BEQ:     return 2'b10;
            JAL:     return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [2:0] alu_ref(logic [6:0] op, logic [2:0] f3, logic f7);
        case (f3)
            3'b000:  return (op == RT && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected control word in cycle k (0 = fetch) of an instruction.
    function automatic ctl_t model(logic [6:0] op, logic [2:0] f3, logic f7, logic z, int k);
        ctl_t c;
        c = '0;
        c.imm = imm_ref(op);
        if (k == 0) begin
            c.ir_write = 1'b1; c.pc_write = 1'b1; c.src_b = 2'b10; c.result_src = 2'b10;
        end else if (k == 1) begin
            c.src_a = 2'b01; c.src_b = 2'b01;
        end else begin
            case (op)
                LW: begin
                    if (k == 2) begin c.src_a = 2'b10; c.src_b = 2'b01; end
                    else if (k == 3) c.adr_src = 1'b1;
                    else begin c.result_src = 2'b01; c.reg_write = 1'b1; end
                end
                SW: begin
                    if (k == 2) begin c.src_a = 2'b10; c.src_b = 2'b01; end
                    else begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
                end
                RT, IT: begin
                    if (k == 2) begin
                        c.src_a = 2'b10;
                        c.src_b = (op == IT) ? 2'b01 : 2'b00;
                        c.alu   = alu_ref(op, f3, f7);
                    end else c.reg_write = 1'b1;
                end
                JAL: begin
                    if (k == 2) begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_write = 1'b1; end
                    else c.reg_write = 1'b1;
                end
                BEQ: begin
                    c.src_a = 2'b10; c.alu = 3'b001; c.pc_write = z;
                end
                default: ;
            endcase
        end
        return c;
    endfunction

    function automatic ctl_t sample();
        ctl_t c;
        c.pc_write = pc_write; c.adr_src = adr_src; c.mem_write = mem_write;
        c.ir_write = ir_write; c.result_src = result_src; c.src_a = alu_src_a;
        c.src_b = alu_src_b; c.alu = alu_control; c.imm = imm_src; c.reg_write = reg_write;
        return c;
    endfunction

    task automatic check_ctl(input string name, input int k, input ctl_t got, input ctl_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%b required=%b (pw adr mw ir rs a b alu imm rw)",
                     name, k, got, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z);
        opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
    endtask

    // Entered just after a rising edge with the FSM in FETCH; leaves the same way.
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z, input int len,
                             output logic [2:0] key_alu, output logic key_pw,
                             output logic [1:0] key_imm);
        int key_k;
        ctl_t got;
        key_k = (len > 2) ? 2 : len - 1;
        key_alu = '0; key_pw = 1'b0; key_imm = '0;
        for (int k = 0; k < len; k++) begin
            drive(op, f3, f7, z);
            @(negedge clock);
            got = sample();
            check_ctl(name, k, got, model(op, f3, f7, z, k));
            if (k == key_k) begin
                key_alu = got.alu; key_pw = got.pc_write; key_imm = got.imm;
            end
            @(posedge clock);
            #1;
        end
    endtask

    vec_t tbl[11];
    logic [2:0] k_alu;
    logic       k_pw;
    logic [1:0] k_imm;
    ctl_t       rst_exp;
    logic [6:0] ops[8];

    initial begin
        tbl = '{
            '{LW,  3'b010, 1'b0, 1'b0, 5, 3'b000, 1'b0, 2'b00},
            '{SW,  3'b010, 1'b0, 1'b0, 4, 3'b000, 1'b0, 2'b01},
            '{RT,  3'b000, 1'b1, 1'b0, 4, 3'b001, 1'b0, 2'b00},
            '{RT,  3'b000, 1'b0, 1'b0, 4, 3'b000, 1'b0, 2'b00},
            '{IT,  3'b000, 1'b1, 1'b0, 4, 3'b000, 1'b0, 2'b00},
            '{RT,  3'b010, 1'b0, 1'b0, 4, 3'b101, 1'b0, 2'b00},
            '{RT,  3'b110, 1'b0, 1'b0, 4, 3'b011, 1'b0, 2'b00},
            '{IT,  3'b111, 1'b0, 1'b0, 4, 3'b010, 1'b0, 2'b00},
            '{BEQ, 3'b000, 1'b0, 1'b1, 3, 3'b001, 1'b1, 2'b10},
            '{BEQ, 3'b000, 1'b0, 1'b0, 3, 3'b001, 1'b0, 2'b10},
            '{JAL, 3'b000, 1'b0, 1'b0, 4, 3'b000, 1'b1, 2'b11}
        };
        ops = '{LW, SW, RT, IT, JAL, BEQ, BAD, 7'b0};

        // Power-up reset: FETCH values with all strobes held low.
        reset = 1'b1;
        drive(7'b0, 3'b0, 1'b0, 1'b1);
        #3;
        rst_exp = model(7'b0, 3'b0, 1'b0, 1'b1, 0);
        rst_exp.ir_write = 1'b0; rst_exp.pc_write = 1'b0;
        check_ctl("por_reset", 0, sample(), rst_exp);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_instr("table", tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].z, tbl[i].len,
                      k_alu, k_pw, k_imm);
            check_val("table_alu", k_alu, tbl[i].key_alu);
            check_val("table_pc_write", {2'b0, k_pw}, {2'b0, tbl[i].key_pw});
            check_val("table_imm", {1'b0, k_imm}, {1'b0, tbl[i].imm});
        end

        // Illegal opcode: DECODE then straight back to FETCH.
        run_instr("illegal", BAD, 3'b000, 1'b0, 1'b1, 2, k_alu, k_pw, k_imm);
        run_instr("after_illegal", LW, 3'b010, 1'b0, 1'b0, 5, k_alu, k_pw, k_imm);

        // Reset asserted in the middle of a MEMWRITE cycle and held for 3 edges.
        for (int k = 0; k < 4; k++) begin
            drive(SW, 3'b010, 1'b0, 1'b1);
            @(negedge clock);
            check_ctl("sw_pre_reset", k, sample(), model(SW, 3'b010, 1'b0, 1'b1, k));
            if (k < 3) begin
                @(posedge clock); #1;
            end
        end
        #2 reset = 1'b1;
        #1;
        rst_exp = model(SW, 3'b010, 1'b0, 1'b1, 0);
        rst_exp.ir_write = 1'b0; rst_exp.pc_write = 1'b0;
        check_ctl("mid_reset", 0, sample(), rst_exp);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clock); #1;
            check_ctl("hold_reset_post", k, sample(), rst_exp);
            @(negedge clock);
            check_ctl("hold_reset_neg", k, sample(), rst_exp);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        run_instr("post_reset", SW, 3'b010, 1'b0, 1'b1, 4, k_alu, k_pw, k_imm);

        // Random instruction stream against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic       f7, z;
            op = ops[$urandom_range(0, 7)];
            if (op == 7'b0) op = 7'($urandom);
            f3 = 3'($urandom);
            f7 = 1'($urandom);
            z  = 1'($urandom);
            run_instr("random", op, f3, f7, z, instr_len(op), k_alu, k_pw, k_imm);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
